// File: rtl/operand_fetch_sequencer.sv
// Sequences one 6502 instruction fetch (opcode, operands, zero-page pointer) over a byte bus
// and produces the resolved effective address, page-cross flag and next PC.
module operand_fetch_sequencer #(
    parameter logic [15:0] RESET_PC = 16'h0200
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        flush,
    input  logic [15:0] pc_in,
    input  logic [7:0]  reg_x,
    input  logic [7:0]  reg_y,
    input  logic [2:0]  addr_mode,
    input  logic [1:0]  inst_length,
    input  logic        idx_sel_y,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ready,
    input  logic [7:0]  mem_rdata,
    output logic        busy,
    output logic        done,
    output logic [7:0]  opcode_q,
    output logic [7:0]  operand1_q,
    output logic [7:0]  operand2_q,
    output logic [15:0] eff_addr,
    output logic        page_crossed,
    output logic [15:0] next_pc
);

    typedef enum logic [2:0] {
        IDLE, FETCH_OP, DECODE, FETCH_B1, FETCH_B2, PTR_LO, PTR_HI, DONE
    } state_e;

    typedef enum logic [2:0] {
        M_IMP, M_IMM, M_ZP, M_ZPX, M_ABS, M_ABSIDX, M_INDX, M_INDY
    } mode_e;

    state_e      state;
    mode_e       mode_q, mode_n;
    logic [15:0] pc_q;
    logic [1:0]  len_q, len_n;
    logic        idx_y_q, idx_y_n;
    logic [7:0]  x_q, x_n, y_q, y_n;
    logic [7:0]  ptr_lo_q;
    logic [7:0]  op1_n, op2_n, ptr_n, ptr_p1;
    logic [15:0] base, sum, eff_n, next_pc_n;
    logic        crossed_n, is_ind, go_done;

    // Values as they will stand after this cycle's capture, so the result can be
    // registered on the same edge that takes in the final byte.
    always_comb begin
        mode_n    = (state == DECODE) ? mode_e'(addr_mode) : mode_q;
        len_n     = (state == DECODE) ? inst_length : len_q;
        idx_y_n   = (state == DECODE) ? idx_sel_y : idx_y_q;
        x_n       = (state == DECODE) ? reg_x : x_q;
        y_n       = (state == DECODE) ? reg_y : y_q;
        op1_n     = (state == FETCH_B1) ? mem_rdata : operand1_q;
        op2_n     = (state == FETCH_B2) ? mem_rdata : operand2_q;
        is_ind    = (mode_n == M_INDX) || (mode_n == M_INDY);
        ptr_n     = (mode_n == M_INDX) ? op1_n + x_n : op1_n;
        ptr_p1    = ptr_n + 8'd1;
        next_pc_n = pc_q + {14'd0, len_n};
        base      = '0;
        sum       = '0;
        eff_n     = '0;
        crossed_n = 1'b0;
        case (mode_n)
            M_IMP:    eff_n = '0;
            M_IMM:    eff_n = pc_q + 16'd1;
            M_ZP:     eff_n = {8'h00, op1_n};
            M_ZPX:    eff_n = {8'h00, op1_n + x_n};
            M_ABS:    eff_n = {op2_n, op1_n};
            M_ABSIDX: begin
                base      = {op2_n, op1_n};
                sum       = base + {8'h00, idx_y_n ? y_n : x_n};
                eff_n     = sum;
                crossed_n = sum[15:8] != base[15:8];
            end
            M_INDX:   eff_n = {mem_rdata, ptr_lo_q};
            M_INDY: begin
                base      = {mem_rdata, ptr_lo_q};
                sum       = base + {8'h00, y_n};
                eff_n     = sum;
                crossed_n = sum[15:8] != base[15:8];
            end
            default:  eff_n = '0;
        endcase
        go_done = ((state == DECODE) && (len_n < 2'd2)) ||
                  ((state == FETCH_B1) && mem_ready && (len_q != 2'd3) && !is_ind) ||
                  ((state == FETCH_B2) && mem_ready && !is_ind) ||
                  ((state == PTR_HI) && mem_ready);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            mem_req      <= 1'b0;
            mem_addr     <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            opcode_q     <= '0;
            operand1_q   <= '0;
            operand2_q   <= '0;
            eff_addr     <= RESET_PC;
            next_pc      <= RESET_PC;
            page_crossed <= 1'b0;
            pc_q         <= '0;
            mode_q       <= M_IMP;
            len_q        <= '0;
            idx_y_q      <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
            ptr_lo_q     <= '0;
        end else if (flush) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        pc_q     <= pc_in;
                        mem_addr <= pc_in;
                        mem_req  <= 1'b1;
                        busy     <= 1'b1;
                        state    <= FETCH_OP;
                    end
                end
                FETCH_OP: if (mem_ready) begin
                    opcode_q <= mem_rdata;
                    mem_req  <= 1'b0;
                    state    <= DECODE;
                end
                DECODE: begin
                    mode_q  <= mode_n;
                    len_q   <= len_n;
                    idx_y_q <= idx_y_n;
                    x_q     <= x_n;
                    y_q     <= y_n;
                    if (!go_done) begin
                        mem_addr <= pc_q + 16'd1;
                        mem_req  <= 1'b1;
                        state    <= FETCH_B1;
                    end
                end
                FETCH_B1: if (mem_ready) begin
                    operand1_q <= mem_rdata;
                    if (len_q == 2'd3) begin
                        mem_addr <= pc_q + 16'd2;
                        state    <= FETCH_B2;
                    end else if (is_ind) begin
                        mem_addr <= {8'h00, ptr_n};
                        state    <= PTR_LO;
                    end
                end
                FETCH_B2: if (mem_ready) begin
                    operand2_q <= mem_rdata;
                    if (is_ind) begin
                        mem_addr <= {8'h00, ptr_n};
                        state    <= PTR_LO;
                    end
                end
                PTR_LO: if (mem_ready) begin
                    ptr_lo_q <= mem_rdata;
                    mem_addr <= {8'h00, ptr_p1};
                    state    <= PTR_HI;
                end
                PTR_HI: ;
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
            if (go_done) begin
                mem_req      <= 1'b0;
                done         <= 1'b1;
                eff_addr     <= eff_n;
                page_crossed <= crossed_n;
                next_pc      <= next_pc_n;
                state        <= DONE;
            end
        end
    end

endmodule

// File: tb/tb_operand_fetch_sequencer.sv
// Scoreboard bench for operand_fetch_sequencer: directed programs in a byte memory model,
// expected bus addresses and results queued by the driver, checked by a separate monitor.
module tb_operand_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst_n, start, flush;
    logic [15:0] pc_in;
    logic [7:0]  reg_x, reg_y;
    logic [2:0]  addr_mode;
    logic [1:0]  inst_length;
    logic        idx_sel_y;
    logic        mem_req, mem_ready;
    logic [15:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic        busy, done, page_crossed;
    logic [7:0]  opcode_q, operand1_q, operand2_q;
    logic [15:0] eff_addr, next_pc;

    logic [7:0]  mem [0:65535];
    logic [15:0] stall_addr;
    int unsigned stall_cycles;
    int unsigned stall_seen = 0;
    int          cyc = 0;

    typedef struct {
        string       name;
        logic [15:0] eff;
        logic        crossed;
        logic [15:0] npc;
        int          exp_cyc;
    } exp_t;

    exp_t        sb_q[$];
    logic [15:0] addr_q[$];
    int          tests = 0;
    int          fails = 0;
    int          done_cnt = 0;

    always #5 clk = ~clk;

    operand_fetch_sequencer #(.RESET_PC(16'h0200)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .flush(flush), .pc_in(pc_in),
        .reg_x(reg_x), .reg_y(reg_y), .addr_mode(addr_mode), .inst_length(inst_length),
        .idx_sel_y(idx_sel_y), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .busy(busy), .done(done), .opcode_q(opcode_q),
        .operand1_q(operand1_q), .operand2_q(operand2_q), .eff_addr(eff_addr),
        .page_crossed(page_crossed), .next_pc(next_pc)
    );

    assign mem_rdata = mem[mem_addr];
    assign mem_ready = !(mem_req && (mem_addr == stall_addr) && (stall_seen < stall_cycles));

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_req && (mem_addr == stall_addr)) stall_seen <= stall_seen + 1;
        else stall_seen <= 0;
    end

    // Instruction decoder stand-in for the opcodes used below.
    always_comb begin
        addr_mode   = 3'd0;
        inst_length = 2'd1;
        idx_sel_y   = 1'b0;
        case (opcode_q)
            8'hA9: begin addr_mode = 3'd1; inst_length = 2'd2; end
            8'hA5: begin addr_mode = 3'd2; inst_length = 2'd2; end
            8'hB5: begin addr_mode = 3'd3; inst_length = 2'd2; end
            8'h8D: begin addr_mode = 3'd4; inst_length = 2'd3; end
            8'hBD: begin addr_mode = 3'd5; inst_length = 2'd3; end
            8'hB9: begin addr_mode = 3'd5; inst_length = 2'd3; idx_sel_y = 1'b1; end
            8'hA1: begin addr_mode = 3'd6; inst_length = 2'd2; end
            8'hB1: begin addr_mode = 3'd7; inst_length = 2'd2; end
            default: ;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every completed bus read and every done pulse is matched against the queues.
    initial forever begin
        @(negedge clk);
        if (mem_req && mem_ready) begin
            if (addr_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_read: got %0h expected no read", mem_addr);
            end else begin
                chk("read_addr", {16'h0, mem_addr}, {16'h0, addr_q.pop_front()});
            end
        end
        if (done) begin
            done_cnt++;
            if (sb_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_done: got eff %0h expected no done", eff_addr);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk({e.name, " eff_addr"}, {16'h0, eff_addr}, {16'h0, e.eff});
                chk({e.name, " page_crossed"}, {31'h0, page_crossed}, {31'h0, e.crossed});
                chk({e.name, " next_pc"}, {16'h0, next_pc}, {16'h0, e.npc});
                chk({e.name, " done_cycle"}, cyc, e.exp_cyc);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int k = 0;
        while ((sb_q.size() != 0 || addr_q.size() != 0) && k < 100) begin
            tick();
            k++;
        end
        if (k >= 100) begin
            tests++; fails++;
            $display("FAIL %s timeout: got %0d pending expected 0", name, sb_q.size() + addr_q.size());
            sb_q.delete();
            addr_q.delete();
        end
    endtask

    task automatic run(input string name, input logic [15:0] pc, input int lat,
                       input logic [15:0] eff, input logic cr, input logic [15:0] npc,
                       input int n, input logic [15:0] a0, input logic [15:0] a1,
                       input logic [15:0] a2, input logic [15:0] a3, input int hold);
        exp_t e;
        logic [15:0] al [4];
        al[0] = a0; al[1] = a1; al[2] = a2; al[3] = a3;
        for (int i = 0; i < n; i++) addr_q.push_back(al[i]);
        e.name = name; e.eff = eff; e.crossed = cr; e.npc = npc; e.exp_cyc = cyc + lat;
        sb_q.push_back(e);
        pc_in = pc;
        start = 1'b1;
        repeat (hold) tick();
        start = 1'b0;
        drain(name);
    endtask

    task automatic wait_addr(input string name, input logic [15:0] a);
        int k = 0;
        while (!(mem_req && mem_addr == a) && k < 30) begin
            tick();
            k++;
        end
        if (k >= 30) begin
            tests++; fails++;
            $display("FAIL %s wait: got addr %0h expected %0h", name, mem_addr, a);
        end
    endtask

    initial begin
        int dc;
        rst_n = 1'b0; start = 1'b0; flush = 1'b0; pc_in = '0;
        reg_x = 8'h05; reg_y = 8'h0A;
        stall_addr = 16'hFFFF; stall_cycles = 0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h0200] = 8'hA9; mem[16'h0201] = 8'h55;
        mem[16'h0300] = 8'hBD; mem[16'h0301] = 8'h34; mem[16'h0302] = 8'h12;
        mem[16'h0310] = 8'hBD; mem[16'h0311] = 8'h34; mem[16'h0312] = 8'h12;
        mem[16'h0400] = 8'hA1; mem[16'h0401] = 8'h20;
        mem[16'h0410] = 8'hA1; mem[16'h0411] = 8'hFB;
        mem[16'h0500] = 8'hB1; mem[16'h0501] = 8'h30;
        mem[16'h0510] = 8'hB1; mem[16'h0511] = 8'hFF;
        mem[16'h0600] = 8'h8D; mem[16'h0601] = 8'h56; mem[16'h0602] = 8'h34;
        mem[16'h0700] = 8'hAA;
        mem[16'h0800] = 8'hA5; mem[16'h0801] = 8'h44;
        mem[16'h0810] = 8'hB5; mem[16'h0811] = 8'hFE;
        mem[16'h0820] = 8'hB9; mem[16'h0821] = 8'hFF; mem[16'h0822] = 8'h10;
        mem[16'h0025] = 8'h00; mem[16'h0026] = 8'h30;
        mem[16'h0000] = 8'h34; mem[16'h0001] = 8'h12;
        mem[16'h0030] = 8'hF8; mem[16'h0031] = 8'h12;
        mem[16'h00FF] = 8'h10;

        repeat (3) tick();
        chk("rst busy", {31'h0, busy}, 32'h0);
        chk("rst done", {31'h0, done}, 32'h0);
        chk("rst mem_req", {31'h0, mem_req}, 32'h0);
        chk("rst mem_addr", {16'h0, mem_addr}, 32'h0);
        chk("rst eff_addr", {16'h0, eff_addr}, 32'h0200);
        chk("rst next_pc", {16'h0, next_pc}, 32'h0200);
        chk("rst opcode_q", {24'h0, opcode_q}, 32'h0);
        chk("rst page_crossed", {31'h0, page_crossed}, 32'h0);
        rst_n = 1'b1;
        tick();

        run("T1_imm",    16'h0200, 4, 16'h0201, 1'b0, 16'h0202, 2, 16'h0200, 16'h0201, 16'h0, 16'h0, 1);
        run("zp",        16'h0800, 4, 16'h0044, 1'b0, 16'h0802, 2, 16'h0800, 16'h0801, 16'h0, 16'h0, 1);
        run("zpx_wrap",  16'h0810, 4, 16'h0003, 1'b0, 16'h0812, 2, 16'h0810, 16'h0811, 16'h0, 16'h0, 1);
        run("T2_absx",   16'h0300, 5, 16'h1239, 1'b0, 16'h0303, 3, 16'h0300, 16'h0301, 16'h0302, 16'h0, 1);
        reg_x = 8'hCC;
        run("T2_absx_cr", 16'h0310, 5, 16'h1300, 1'b1, 16'h0313, 3, 16'h0310, 16'h0311, 16'h0312, 16'h0, 1);
        reg_x = 8'h05;
        run("absy_cr",   16'h0820, 5, 16'h1109, 1'b1, 16'h0823, 3, 16'h0820, 16'h0821, 16'h0822, 16'h0, 1);
        run("T3_indx",   16'h0400, 6, 16'h3000, 1'b0, 16'h0402, 4, 16'h0400, 16'h0401, 16'h0025, 16'h0026, 1);
        run("T3_indx_wr", 16'h0410, 6, 16'h1234, 1'b0, 16'h0412, 4, 16'h0410, 16'h0411, 16'h0000, 16'h0001, 1);
        run("T4_indy",   16'h0500, 6, 16'h1302, 1'b1, 16'h0502, 4, 16'h0500, 16'h0501, 16'h0030, 16'h0031, 1);
        run("T4_indy_wr", 16'h0510, 6, 16'h341A, 1'b0, 16'h0512, 4, 16'h0510, 16'h0511, 16'h00FF, 16'h0000, 1);
        stall_addr = 16'h0602; stall_cycles = 3;
        run("T5_wait",   16'h0600, 8, 16'h3456, 1'b0, 16'h0603, 3, 16'h0600, 16'h0601, 16'h0602, 16'h0, 1);
        stall_addr = 16'hFFFF; stall_cycles = 0;
        run("T6_imp",    16'h0700, 3, 16'h0000, 1'b0, 16'h0701, 1, 16'h0700, 16'h0, 16'h0, 16'h0, 2);

        // Asynchronous reset while the pointer low byte is on the bus.
        dc = done_cnt;
        addr_q.push_back(16'h0400); addr_q.push_back(16'h0401);
        pc_in = 16'h0400; start = 1'b1; tick(); start = 1'b0;
        wait_addr("rst_ptr", 16'h0025);
        rst_n = 1'b0;
        #1;
        chk("rst_ptr mem_req", {31'h0, mem_req}, 32'h0);
        chk("rst_ptr busy", {31'h0, busy}, 32'h0);
        chk("rst_ptr eff_addr", {16'h0, eff_addr}, 32'h0200);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        addr_q.delete();
        chk("rst_ptr no_done", done_cnt, dc);

        // Flush while the first operand byte is being read.
        dc = done_cnt;
        addr_q.push_back(16'h0300); addr_q.push_back(16'h0301);
        pc_in = 16'h0300; start = 1'b1; tick(); start = 1'b0;
        wait_addr("flush_b1", 16'h0301);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_b1 busy", {31'h0, busy}, 32'h0);
        chk("flush_b1 mem_req", {31'h0, mem_req}, 32'h0);
        repeat (4) tick();
        addr_q.delete();
        chk("flush_b1 no_done", done_cnt, dc);

        // Start and flush together in IDLE: flush wins.
        pc_in = 16'h0200; start = 1'b1; flush = 1'b1;
        tick();
        start = 1'b0; flush = 1'b0;
        chk("start_flush busy", {31'h0, busy}, 32'h0);
        chk("start_flush mem_req", {31'h0, mem_req}, 32'h0);
        repeat (2) tick();
        chk("start_flush no_done", done_cnt, dc);

        run("T1_again",  16'h0200, 4, 16'h0201, 1'b0, 16'h0202, 2, 16'h0200, 16'h0201, 16'h0, 16'h0, 1);
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
